// File: rtl/dev_io_pkg.sv
`default_nettype none
// ============================================================================
// dev_io_pkg : shared FSM state type and 7-segment decode for dev_io_ctrl
// Rev 1.0
// ============================================================================
package dev_io_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    HALTED = 2'd2
  } io_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, seg a on bit 0 (DE2 board wiring).
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : synchroniser, stability counter, debounced level, press pulse
// Rev 1.0
// ============================================================================
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= ~key_n;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dev_io_ctrl.sv
`default_nettype none
// ============================================================================
// dev_io_ctrl : key debounce, RUN/PAUSED/HALTED cpu clock-enable FSM, 7-seg drive
// Optional DEV_IO_LZB_EN: leading-zero blanking on the display.  Rev 1.0
// ============================================================================
module dev_io_ctrl
  import dev_io_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV    = 1,
  parameter int N_DIGITS   = 4,
  parameter int START_RUN  = 1
) (
  input  logic                  clkIn,
  input  logic                  reset,
  input  logic [N_KEYS-1:0]     key_n,
  input  logic                  halt_in,
  input  logic [4*N_DIGITS-1:0] disp_value,
  output logic                  cpu_ce,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [1:0]            state_o,
  output logic [N_DIGITS*7-1:0] hex_n
);

  localparam int               DIV_W    = $clog2(RUN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clkIn),
      .reset (reset),
      .key_n (key_n[k]),
      .level (key_level[k]),
      .press (key_press[k])
    );
  end

  io_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_d;

  always_ff @(posedge clkIn) begin
    if (reset) begin
      state_q <= (START_RUN != 0) ? RUN : PAUSED;
      div_q   <= '0;
      cpu_ce  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cpu_ce  <= ce_d;
    end
  end

  // Priority within a cycle: halt, then pause/resume, then step.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_in) begin
          state_d = HALTED;
        end else if (key_press[0]) begin
          state_d = PAUSED;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          ce_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      PAUSED: begin
        if (halt_in) begin
          state_d = HALTED;
        end else if (key_press[0]) begin
          state_d = RUN;
          div_d   = '0;
        end else begin
          ce_d = key_press[1];
        end
      end
      default: state_d = HALTED;
    endcase
  end

  assign state_o = state_q;

  logic [N_DIGITS*7-1:0] hex_d;
  logic [3:0]            nib;
`ifdef DEV_IO_LZB_EN
  logic                  seen;
`endif

  always_comb begin
    hex_d = '1;
    nib   = '0;
`ifdef DEV_IO_LZB_EN
    seen  = 1'b0;
`endif
    // Walk from the top digit so blanking stops at the first non-zero nibble.
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      nib = disp_value[4*d +: 4];
`ifdef DEV_IO_LZB_EN
      seen = seen | (nib != 4'h0) | (d == 0);
      hex_d[7*d +: 7] = seen ? hex7(nib) : SEG_BLANK;
`else
      hex_d[7*d +: 7] = hex7(nib);
`endif
    end
  end

  always_ff @(posedge clkIn) begin
    if (reset) begin
      hex_n <= '1;
    end else begin
      hex_n <= hex_d;
    end
  end

endmodule
`default_nettype wire
